// File: rtl/cpu_mem_interface.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_interface
// Purpose  : Memory-side stage behind the CPU control FSM. Holds the program
//            counter, the data-address register and the instruction register,
//            selects the bus address, drives a synchronous-read RAM, decodes
//            the memory-mapped LED (write-only) and switch (read-only)
//            registers, and records the first illegal bus access.
// Ports    : clk_i          rising-edge clock
//            reset_i        synchronous active-high reset
//            load_pc_i      PC update strobe (increment, or clear with reset_pc_i)
//            reset_pc_i     with load_pc_i, clears the PC
//            addr_sel_i     1: bus address = PC, 0: bus address = data address
//            load_ir_i      IR captures read_data_o
//            load_addr_i    data address captures datapath_out_i[8:0]
//            mem_cmd_i      00 none, 01 read, 10 write, 11 illegal
//            datapath_out_i address source and write data
//            ram_dout_i     RAM read data (one cycle after ram_addr_o)
//            sw_in_i        asynchronous slide switches
//            ram_addr_o     RAM address (bus address [7:0])
//            ram_din_o      RAM write data
//            ram_we_o       RAM write enable
//            read_data_o    read data to datapath and IR
//            ir_out_o       instruction register
//            pc_out_o       program counter
//            led_out_o      LED register
//            bus_err_o      sticky illegal-access flag
//            err_addr_o     bus address of the first illegal access
// Revision : 1.0  initial release
// ============================================================================
module cpu_mem_interface #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_pc_i,
  input  logic        reset_pc_i,
  input  logic        addr_sel_i,
  input  logic        load_ir_i,
  input  logic        load_addr_i,
  input  logic [1:0]  mem_cmd_i,
  input  logic [15:0] datapath_out_i,
  input  logic [15:0] ram_dout_i,
  input  logic [7:0]  sw_in_i,
  output logic [7:0]  ram_addr_o,
  output logic [15:0] ram_din_o,
  output logic        ram_we_o,
  output logic [15:0] read_data_o,
  output logic [15:0] ir_out_o,
  output logic [8:0]  pc_out_o,
  output logic [7:0]  led_out_o,
  output logic        bus_err_o,
  output logic [8:0]  err_addr_o
);

  localparam logic [1:0] C_CMD_READ  = 2'b01;
  localparam logic [1:0] C_CMD_WRITE = 2'b10;
  localparam logic [1:0] C_CMD_ILL   = 2'b11;

  logic [8:0]  pc_q, pc_d;
  logic [8:0]  daddr_q, daddr_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;
  logic        bus_err_q, bus_err_d;
  logic [8:0]  err_addr_q, err_addr_d;

  logic [8:0]  w_mem_addr;
  logic        w_rd, w_wr;
  logic        w_is_ram, w_is_led, w_is_sw;
  logic        w_illegal;
  logic [15:0] w_read_data;

  // Bus address comes only from register outputs, so a same-cycle
  // load_pc/load_addr affects the following access, not this one.
  assign w_mem_addr = addr_sel_i ? pc_q : daddr_q;

  assign w_rd     = (mem_cmd_i == C_CMD_READ);
  assign w_wr     = (mem_cmd_i == C_CMD_WRITE);
  assign w_is_ram = ~w_mem_addr[8];
  assign w_is_led = (w_mem_addr == LED_ADDR);
  assign w_is_sw  = (w_mem_addr == SW_ADDR);

  assign w_illegal = (mem_cmd_i == C_CMD_ILL)
                   | ((w_rd | w_wr) & w_mem_addr[8] & ~w_is_led & ~w_is_sw)
                   | (w_rd & w_is_led)
                   | (w_wr & w_is_sw);

  always_comb begin
    w_read_data = 16'h0000;
    if (w_rd && w_is_ram) begin
      w_read_data = ram_dout_i;
    end else if (w_rd && w_is_sw) begin
      w_read_data = {8'h00, sw_sync_q};
    end
  end

  always_comb begin
    pc_d       = pc_q;
    daddr_d    = daddr_q;
    ir_d       = ir_q;
    led_d      = led_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;

    if (load_pc_i) begin
      pc_d = reset_pc_i ? 9'h000 : pc_q + 9'h001;
    end
    if (load_addr_i) begin
      daddr_d = datapath_out_i[8:0];
    end
    if (load_ir_i) begin
      ir_d = w_read_data;
    end
    // An illegal access never matches the legal LED-write decode, so the
    // LED update needs no extra qualification.
    if (w_wr && w_is_led) begin
      led_d = datapath_out_i[7:0];
    end
    if (w_illegal) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) begin
        err_addr_d = w_mem_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= 9'h000;
      daddr_q    <= 9'h000;
      ir_q       <= 16'h0000;
      led_q      <= 8'h00;
      sw_meta_q  <= 8'h00;
      sw_sync_q  <= 8'h00;
      bus_err_q  <= 1'b0;
      err_addr_q <= 9'h000;
    end else begin
      pc_q       <= pc_d;
      daddr_q    <= daddr_d;
      ir_q       <= ir_d;
      led_q      <= led_d;
      sw_meta_q  <= sw_in_i;
      sw_sync_q  <= sw_meta_q;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign ram_addr_o  = w_mem_addr[7:0];
  assign ram_din_o   = datapath_out_i;
  assign ram_we_o    = w_wr & w_is_ram & ~reset_i;
  assign read_data_o = w_read_data;
  assign ir_out_o    = ir_q;
  assign pc_out_o    = pc_q;
  assign led_out_o   = led_q;
  assign bus_err_o   = bus_err_q;
  assign err_addr_o  = err_addr_q;

endmodule
`default_nettype wire
